game_controller: RTL and testbench

//  Game sequencer for tic-tac-toe; drives every game-state input of the display block
//  (cursorPos, gridContents, mode, p1Score, p2Score, ties).

---
 rtl/game_controller_pkg.sv | 41 ++++
 rtl/game_controller_win_detect.sv | 36 +++
 rtl/game_controller.sv | 149 ++++++++++++++
 tb/tb_game_controller.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_controller_pkg.sv
// Shared definitions for the tic-tac-toe game sequencer: cell codes, view
// mode code, FSM state encoding and small cursor/tally helpers.
package game_controller_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;

  localparam logic MODE_GAME = 1'b0;

  typedef enum logic [1:0] {
    S_PLAY  = 2'd0,
    S_CHECK = 2'd1,
    S_OVER  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_e;

  // One cursor step on the row-major 3x3 board, wrapping within the row/column.
  function automatic logic [3:0] cursor_step(input logic [3:0] pos, input dir_e dir);
    logic [3:0] col;
    col = pos % 4'd3;
    unique case (dir)
      DIR_UP:    cursor_step = (pos >= 4'd3) ? pos - 4'd3 : pos + 4'd6;
      DIR_DOWN:  cursor_step = (pos <= 4'd5) ? pos + 4'd3 : pos - 4'd6;
      DIR_LEFT:  cursor_step = (col == 4'd0) ? pos + 4'd2 : pos - 4'd1;
      DIR_RIGHT: cursor_step = (col == 4'd2) ? pos - 4'd2 : pos + 4'd1;
    endcase
  endfunction

  // Tally increment that holds once the ceiling is reached.
  function automatic logic [7:0] sat_inc(input logic [7:0] value, input logic [7:0] ceiling);
    sat_inc = (value >= ceiling) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/game_controller_win_detect.sv
// Combinational board evaluator: reports the owner of any completed line and
// whether every cell is occupied.
module game_controller_win_detect
  import game_controller_pkg::*;
(
  input  logic [17:0] grid_i,
  output logic [1:0]  winner_o,
  output logic        full_o
);

  // Cell indices of the eight lines: three rows, three columns, two diagonals.
  localparam int LINE_CELLS [24] = '{0, 1, 2,  3, 4, 5,  6, 7, 8,
                                     0, 3, 6,  1, 4, 7,  2, 5, 8,
                                     0, 4, 8,  2, 4, 6};

  // Scan every line for three equal non-empty cells, and every cell for emptiness.
  always_comb begin
    logic [1:0] a, b, c;
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    winner_o = CELL_EMPTY;
    full_o   = 1'b1;
    a        = CELL_EMPTY;
    b        = CELL_EMPTY;
    c        = CELL_EMPTY;
    for (int k = 0; k < 9; k++) begin
      if (grid_i[2*k +: 2] == CELL_EMPTY) full_o = 1'b0;
    end
    for (int l = 0; l < 8; l++) begin
      a = grid_i[2*LINE_CELLS[3*l]     +: 2];
      b = grid_i[2*LINE_CELLS[3*l + 1] +: 2];
      c = grid_i[2*LINE_CELLS[3*l + 2] +: 2];
      if ((a != CELL_EMPTY) && (a == b) && (b == c)) winner_o = a;
    end
  end

endmodule

// File: rtl/game_controller.sv
// Tic-tac-toe sequencer: cursor movement, mark placement, win/tie evaluation
// and saturating tallies. All outputs come straight from registers.
module game_controller
  import game_controller_pkg::*;
#(
  parameter int CURSOR_INIT = 4,
  parameter int MAX_SCORE   = 99
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btnUp,
  input  logic        btnDown,
  input  logic        btnLeft,
  input  logic        btnRight,
  input  logic        btnSel,
  input  logic        btnMode,
  output logic [3:0]  cursorPos,
  output logic [17:0] gridContents,
  output logic        mode,
  output logic [7:0]  p1Score,
  output logic [7:0]  p2Score,
  output logic [7:0]  ties,
  output logic        turn,
  output logic        gameOver
);

  localparam logic [3:0] CURSOR_RST = 4'(CURSOR_INIT);
  localparam logic [7:0] SCORE_MAX  = 8'(MAX_SCORE);

  state_e      state_q, state_d;
  logic [17:0] grid_q, grid_d;
  logic [3:0]  cursor_q, cursor_d;
  logic        mode_q, mode_d;
  logic [7:0]  p1_q, p1_d;
  logic [7:0]  p2_q, p2_d;
  logic [7:0]  ties_q, ties_d;
  logic        turn_q, turn_d;
  logic        starter_q, starter_d;

  logic [1:0]  winner;
  logic        full;
  logic [4:0]  cell_lsb;

  assign cell_lsb = {cursor_q, 1'b0};

  game_controller_win_detect u_win_detect (
    .grid_i   (grid_q),
    .winner_o (winner),
    .full_o   (full)
  );

  // Next-state logic: view toggle, cursor moves, mark placement, game evaluation, restart.
  always_comb begin
    state_d   = state_q;
    grid_d    = grid_q;
    cursor_d  = cursor_q;
    mode_d    = mode_q ^ btnMode;
    p1_d      = p1_q;
    p2_d      = p2_q;
    ties_d    = ties_q;
    turn_d    = turn_q;
    starter_d = starter_q;

    unique case (state_q)
      S_PLAY: begin
        if (mode_q == MODE_GAME) begin
          if (btnSel) begin
            // Select consumes the cycle even on an occupied cell, so moves are dropped.
            if (grid_q[cell_lsb +: 2] == CELL_EMPTY) begin
              grid_d[cell_lsb +: 2] = turn_q ? CELL_P2 : CELL_P1;
              state_d               = S_CHECK;
            end
          end else if (btnUp) begin
            cursor_d = cursor_step(cursor_q, DIR_UP);
          end else if (btnDown) begin
            cursor_d = cursor_step(cursor_q, DIR_DOWN);
          end else if (btnLeft) begin
            cursor_d = cursor_step(cursor_q, DIR_LEFT);
          end else if (btnRight) begin
            cursor_d = cursor_step(cursor_q, DIR_RIGHT);
          end
        end
      end

      S_CHECK: begin
        // Only the player who just moved can have completed a line.
        if (winner != CELL_EMPTY) begin
          if (winner == CELL_P1) p1_d = sat_inc(p1_q, SCORE_MAX);
          else                   p2_d = sat_inc(p2_q, SCORE_MAX);
          state_d = S_OVER;
        end else if (full) begin
          ties_d  = sat_inc(ties_q, SCORE_MAX);
          state_d = S_OVER;
        end else begin
          turn_d  = ~turn_q;
          state_d = S_PLAY;
        end
      end

      S_OVER: begin
        if (btnSel) begin
          grid_d    = '0;
          cursor_d  = CURSOR_RST;
          starter_d = ~starter_q;
          turn_d    = ~starter_q;
          state_d   = S_PLAY;
        end
      end

      default: state_d = S_PLAY;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state_q   <= S_PLAY;
      grid_q    <= '0;
      cursor_q  <= CURSOR_RST;
      mode_q    <= 1'b0;
      p1_q      <= '0;
      p2_q      <= '0;
      ties_q    <= '0;
      turn_q    <= 1'b0;
      starter_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grid_q    <= grid_d;
      cursor_q  <= cursor_d;
      mode_q    <= mode_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
      ties_q    <= ties_d;
      turn_q    <= turn_d;
      starter_q <= starter_d;
    end
  end

  assign cursorPos    = cursor_q;
  assign gridContents = grid_q;
  assign mode         = mode_q;
  assign p1Score      = p1_q;
  assign p2Score      = p2_q;
  assign ties         = ties_q;
  assign turn         = turn_q;
  assign gameOver     = (state_q == S_OVER);

endmodule

// File: tb/tb_game_controller.sv
// Testbench for game_controller: directed game scenarios followed by random
// button traffic, every cycle compared against a behavioural board model.
module tb_game_controller;

  localparam int TB_MAX   = 6;
  localparam int PH_PLAY  = 0;
  localparam int PH_CHECK = 1;
  localparam int PH_OVER  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btnUp = 1'b0, btnDown = 1'b0, btnLeft = 1'b0, btnRight = 1'b0;
  logic        btnSel = 1'b0, btnMode = 1'b0;
  logic [3:0]  cursorPos;
  logic [17:0] gridContents;
  logic        mode;
  logic [7:0]  p1Score, p2Score, ties;
  logic        turn, gameOver;

  game_controller #(.CURSOR_INIT(4), .MAX_SCORE(TB_MAX)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btnUp        (btnUp),
    .btnDown      (btnDown),
    .btnLeft      (btnLeft),
    .btnRight     (btnRight),
    .btnSel       (btnSel),
    .btnMode      (btnMode),
    .cursorPos    (cursorPos),
    .gridContents (gridContents),
    .mode         (mode),
    .p1Score      (p1Score),
    .p2Score      (p2Score),
    .ties         (ties),
    .turn         (turn),
    .gameOver     (gameOver)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: board as an array of owners (0 empty, 1 P1, 2 P2).
  int m_grid [9];
  int m_cur, m_mode, m_p1, m_p2, m_ties, m_turn, m_starter, m_phase;
  int seq_q [$];

  function automatic int m_winner();
    for (int r = 0; r < 3; r++)
      if (m_grid[3*r] != 0 && m_grid[3*r] == m_grid[3*r+1] && m_grid[3*r] == m_grid[3*r+2])
        return m_grid[3*r];
    for (int c = 0; c < 3; c++)
      if (m_grid[c] != 0 && m_grid[c] == m_grid[c+3] && m_grid[c] == m_grid[c+6])
        return m_grid[c];
    if (m_grid[4] != 0 && m_grid[0] == m_grid[4] && m_grid[8] == m_grid[4]) return m_grid[4];
    if (m_grid[4] != 0 && m_grid[2] == m_grid[4] && m_grid[6] == m_grid[4]) return m_grid[4];
    return 0;
  endfunction

  function automatic bit m_full();
    for (int k = 0; k < 9; k++) if (m_grid[k] == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [17:0] m_packed();
    logic [17:0] g;
    g = '0;
    for (int k = 0; k < 9; k++) g[2*k +: 2] = 2'(m_grid[k]);
    return g;
  endfunction

  task automatic model_step(input bit r, input bit u, input bit d, input bit l,
                            input bit rt, input bit s, input bit md);
    int w, row, col, old_mode;
    if (!r) begin
      for (int k = 0; k < 9; k++) m_grid[k] = 0;
      m_cur = 4; m_mode = 0; m_p1 = 0; m_p2 = 0; m_ties = 0;
      m_turn = 0; m_starter = 0; m_phase = PH_PLAY;
      return;
    end
    old_mode = m_mode;
    if (md) m_mode = 1 - m_mode;
    case (m_phase)
      PH_PLAY: begin
        if (old_mode == 0) begin
          if (s) begin
            if (m_grid[m_cur] == 0) begin
              m_grid[m_cur] = m_turn + 1;
              m_phase = PH_CHECK;
            end
          end else begin
            row = m_cur / 3;
            col = m_cur % 3;
            if (u)       row = (row + 2) % 3;
            else if (d)  row = (row + 1) % 3;
            else if (l)  col = (col + 2) % 3;
            else if (rt) col = (col + 1) % 3;
            m_cur = row * 3 + col;
          end
        end
      end
      PH_CHECK: begin
        w = m_winner();
        if (w == 1) begin
          if (m_p1 < TB_MAX) m_p1++;
          m_phase = PH_OVER;
        end else if (w == 2) begin
          if (m_p2 < TB_MAX) m_p2++;
          m_phase = PH_OVER;
        end else if (m_full()) begin
          if (m_ties < TB_MAX) m_ties++;
          m_phase = PH_OVER;
        end else begin
          m_turn = 1 - m_turn;
          m_phase = PH_PLAY;
        end
      end
      default: begin
        if (s) begin
          for (int k = 0; k < 9; k++) m_grid[k] = 0;
          m_cur = 4;
          m_starter = 1 - m_starter;
          m_turn = m_starter;
          m_phase = PH_PLAY;
        end
      end
    endcase
  endtask

  // One clock: drive inputs, advance model at the edge, compare at the falling edge.
  task automatic cyc(input bit r, input bit u, input bit d, input bit l,
                     input bit rt, input bit s, input bit md);
    rst_n = r; btnUp = u; btnDown = d; btnLeft = l; btnRight = rt; btnSel = s; btnMode = md;
    @(posedge clk);
    model_step(r, u, d, l, rt, s, md);
    @(negedge clk);
    check("cursor", 32'(cursorPos), 32'(m_cur));
    check("grid", 32'(gridContents), 32'(m_packed()));
    check("mode", 32'(mode), 32'(m_mode));
    check("p1", 32'(p1Score), 32'(m_p1));
    check("p2", 32'(p2Score), 32'(m_p2));
    check("ties", 32'(ties), 32'(m_ties));
    check("turn", 32'(turn), 32'(m_turn));
    check("over", 32'(gameOver), 32'(m_phase == PH_OVER));
  endtask

  task automatic idle();      cyc(1, 0, 0, 0, 0, 0, 0); endtask
  task automatic press_sel(); cyc(1, 0, 0, 0, 0, 1, 0); endtask
  task automatic reset2();    cyc(0, 0, 0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0, 0, 0); endtask

  task automatic goto_cell(input int t);
    for (int i = 0; i < 3 && (m_cur % 3) != (t % 3); i++) cyc(1, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3 && (m_cur / 3) != (t / 3); i++) cyc(1, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic play_seq();
    foreach (seq_q[i]) begin
      goto_cell(seq_q[i]);
      press_sel();
      idle();
    end
  endtask

  initial begin
    // 1: reset values and wrapping cursor moves.
    reset2();
    check("rst_cursor", 32'(cursorPos), 32'd4);
    check("rst_grid", 32'(gridContents), 32'd0);
    cyc(1, 0, 0, 0, 1, 0, 0);
    check("t1_right1", 32'(cursorPos), 32'd5);
    cyc(1, 0, 0, 0, 1, 0, 0);
    check("t1_right_wrap", 32'(cursorPos), 32'd3);
    cyc(1, 0, 1, 0, 0, 0, 0);
    check("t1_down", 32'(cursorPos), 32'd6);
    check("t1_grid", 32'(gridContents), 32'd0);

    // 2: P1 takes the top row.
    seq_q = '{0, 3, 1, 4};
    play_seq();
    goto_cell(2);
    press_sel();
    check("t2_over_n1", 32'(gameOver), 32'd0);
    check("t2_p1_n1", 32'(p1Score), 32'd0);
    idle();
    check("t2_p1", 32'(p1Score), 32'd1);
    check("t2_over", 32'(gameOver), 32'd1);
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 0, 0);
    check("t2_frozen_grid", 32'(gridContents), 32'h295);
    check("t2_frozen_cur", 32'(cursorPos), 32'd2);
    press_sel();
    check("t2_restart_grid", 32'(gridContents), 32'd0);
    check("t2_restart_turn", 32'(turn), 32'd1);

    // 3: drawn game, then restart alternates the starter.
    reset2();
    seq_q = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    play_seq();
    check("t3_ties", 32'(ties), 32'd1);
    check("t3_over", 32'(gameOver), 32'd1);
    press_sel();
    check("t3_grid", 32'(gridContents), 32'd0);
    check("t3_cursor", 32'(cursorPos), 32'd4);
    check("t3_turn", 32'(turn), 32'd1);

    // 4: occupied-cell select, and select beating a simultaneous move.
    press_sel();
    idle();
    check("t4_first", 32'(gridContents), 32'h200);
    press_sel();
    idle();
    check("t4_occupied_grid", 32'(gridContents), 32'h200);
    check("t4_occupied_turn", 32'(turn), 32'd0);
    goto_cell(0);
    cyc(1, 1, 0, 0, 0, 1, 0);
    check("t4_selup_cursor", 32'(cursorPos), 32'd0);
    check("t4_selup_grid", 32'(gridContents), 32'h201);
    idle();

    // 5: score view blocks play; saturation of P2 wins.
    cyc(1, 0, 0, 0, 0, 0, 1);
    check("t5_mode1", 32'(mode), 32'd1);
    cyc(1, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 1, 0, 0, 0, 0);
    check("t5_cursor", 32'(cursorPos), 32'd0);
    check("t5_grid", 32'(gridContents), 32'h201);
    cyc(1, 0, 0, 0, 0, 0, 1);
    check("t5_mode0", 32'(mode), 32'd0);
    reset2();
    for (int g = 0; g < TB_MAX + 2; g++) begin
      if (m_turn == 0) seq_q = '{0, 3, 1, 4, 8, 5};
      else             seq_q = '{3, 0, 4, 1, 5};
      play_seq();
      press_sel();
    end
    check("t5_p2_sat", 32'(p2Score), 32'(TB_MAX));
    check("t5_p1", 32'(p1Score), 32'd0);

    // 6: reset while a winning move is being evaluated.
    reset2();
    seq_q = '{0, 3, 1, 4};
    play_seq();
    goto_cell(2);
    press_sel();
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("t6_p1", 32'(p1Score), 32'd0);
    check("t6_over", 32'(gameOver), 32'd0);
    check("t6_grid", 32'(gridContents), 32'd0);
    check("t6_cursor", 32'(cursorPos), 32'd4);
    check("t6_turn", 32'(turn), 32'd0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 999) != 0,
          $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 15,
          $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 15,
          $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 4);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
